cv32e40p_nmr_voter_mon: RTL and testbench
=========================================

# cv32e40p_nmr_voter_mon

Parametrised triple-modular-redundancy voter with health monitoring, the next-generation replacement for the fixed 1-bit/32-bit TMR voters used around replicated core units (ALU, multiplier, etc.). Votes three replica results of configurable width, flags the disagreeing replica, and tracks per-replica consecutive-fault streaks. A replica that persistently disagrees is retired, and voting degrades from TMR to duplex compare. An uncorrectable disagreement is sticky until software clears it.

## Interface
Parameters:
- WIDTH, 32, replica result width (≥1)
- THRESH, 4, consecutive lone-disagreement cycles that retire a replica (2..255)
- CNT_W, 8, width of the saturating total-fault counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- valid_i  in  1  replica results valid this cycle; monitoring only advances when 1
- clear_i  in  1  clears counters, streaks, failed mask, log; returns to TMR mode
- res1_i / res2_i / res3_i  in  WIDTH  replica results
- result_o  out  WIDTH  voted result (combinational)
- faulty_o  out  1  disagreement among healthy replicas this cycle (combinational, gated by valid_i)
- fault_id_o  out  2  lone disagreeing replica: 0 none, 1/2/3 replica index (combinational)
- uncorrectable_o  out  1  no trustworthy majority (combinational; forced 1 in FAIL)
- mode_o  out  2  registered state: 0 TMR, 1 DEG, 2 FAIL
- failed_mask_o  out  3  registered retired-replica mask, bit k-1 = replica k
- fault_cnt_o  out  CNT_W  registered saturating count of valid cycles with faulty_o=1
- log_valid_o  out  1  first-error log captured (see Configuration)
- log_id_o  out  2  replica index of the logged error (0 = uncorrectable)
- log_data_o  out  WIDTH  offending replica value (res1_i when log_id_o=0)

## Operation
- TMR mode, word-level compare:
  - all equal: no fault.
  - exactly one replica differs from the other two, which are equal: faulty_o=1, fault_id_o=that index, result_o=the agreeing value.
  - all three pairwise different: uncorrectable_o=1, fault_id_o=0, result_o=bitwise majority.
- Streaks: per-replica counter (width ceil(log2(THRESH+1))).
  - On a valid cycle, increments for the lone disagreer.
  - Clears for a replica that agrees with the vote.
  - Unchanged on three-way disagreement and when valid_i=0.
- Retirement: when a streak would reach THRESH, the replica's failed_mask bit is set and mode becomes DEG at that edge.
- DEG mode: the failed replica is ignored.
  - result_o = lowest-index healthy replica.
  - If the two healthy replicas differ: faulty_o=1, uncorrectable_o=1, fault_id_o=0, and next mode is FAIL.
  - No further retirement occurs.
- Transitions to FAIL:
  - three-way disagreement on a valid cycle in TMR.
  - healthy-pair mismatch on a valid cycle in DEG.
- FAIL mode: sticky.
  - uncorrectable_o=1 regardless of inputs.
  - result_o = lowest-index healthy replica.
  - Streaks frozen; fault_cnt_o still counts disagreement cycles.
- Counter: fault_cnt_o saturates at 2^CNT_W-1.
- Priority: rst > clear_i > fault updates. Clear and a fault on the same cycle: clear wins and the fault is not recorded.
- valid_i=0: faulty_o, fault_id_o = 0; uncorrectable_o = 0 unless in FAIL; result_o still driven per mode.

## Timing
- Vote and flags are combinational, zero latency from res*_i.
- State, mask, counters and log update at the edge ending the valid cycle; visible the next cycle.
- In the cycle a replica reaches THRESH, voting is still TMR; DEG voting applies from the next cycle.
- Reset values: mode_o=0, failed_mask_o=0, fault_cnt_o=0, all streaks 0, log_valid_o=0, log_id_o=0, log_data_o=0.
- Combinational outputs follow inputs under reset state.
- rst asserted mid-operation: everything returns to reset values at the next edge, including from FAIL.

## Configuration
- CV32E40P_NMR_ERR_LOG_EN defined: on the first valid cycle with faulty_o=1, captures log_id_o=fault_id_o and log_data_o = disagreeing replica value (res1_i if uncorrectable), and sets log_valid_o. The log then holds until clear_i or rst.
- Undefined: log ports present but tied to 0; no log registers.

## Test plan
- WIDTH=32, all replicas 0xDEADBEEF, valid_i=1 for 10 cycles -> result_o=0xDEADBEEF, faulty_o=0, mode_o=0, fault_cnt_o=0.
- res2_i=0x00000001, others 0x5, one valid cycle -> result_o=0x5, fault_id_o=2, fault_cnt_o=1 next cycle; with LOG_EN: log_id_o=2, log_data_o=0x1.
- THRESH=4, replica 3 wrong for 4 consecutive valid cycles (one valid_i=0 gap between cycles 2 and 3) -> mode_o=1, failed_mask_o=3'b100 after the 4th; 3 wrong then agree then 3 wrong -> stays TMR.
- In DEG with replica 3 retired, res1_i=0xA, res2_i=0xB -> uncorrectable_o=1, result_o=0xA, mode_o=2 next cycle; subsequent equal inputs keep uncorrectable_o=1.
- Inputs 0x1/0x2/0x4 in TMR -> uncorrectable_o=1, result_o=0x0 (bitwise majority), mode_o=2; clear_i asserted the same cycle as a fault -> mode_o=0, fault_cnt_o=0, log_valid_o=0.
- CNT_W=2, 5 fault cycles -> fault_cnt_o saturates at 3; rst pulse -> all registered outputs 0 next cycle.

Source files
------------

// File: rtl/cv32e40p_nmr_voter_mon_if.sv
// cv32e40p_nmr_voter_mon_if: replica-result bus plus vote/health outputs of the NMR voter.
// Latency: n/a (signal bundle only).
// Backpressure: none; valid_i only qualifies monitoring, results are consumed every cycle.
interface cv32e40p_nmr_voter_mon_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             valid_i;
  logic             clear_i;
  logic [WIDTH-1:0] res1_i;
  logic [WIDTH-1:0] res2_i;
  logic [WIDTH-1:0] res3_i;
  logic [WIDTH-1:0] result_o;
  logic             faulty_o;
  logic [1:0]       fault_id_o;
  logic             uncorrectable_o;
  logic [1:0]       mode_o;
  logic [2:0]       failed_mask_o;
  logic [CNT_W-1:0] fault_cnt_o;
  logic             log_valid_o;
  logic [1:0]       log_id_o;
  logic [WIDTH-1:0] log_data_o;

  modport master (
    output valid_i, clear_i, res1_i, res2_i, res3_i,
    input  result_o, faulty_o, fault_id_o, uncorrectable_o, mode_o,
    input  failed_mask_o, fault_cnt_o, log_valid_o, log_id_o, log_data_o
  );

  modport slave (
    input  valid_i, clear_i, res1_i, res2_i, res3_i,
    output result_o, faulty_o, fault_id_o, uncorrectable_o, mode_o,
    output failed_mask_o, fault_cnt_o, log_valid_o, log_id_o, log_data_o
  );
endinterface

// File: rtl/cv32e40p_nmr_voter_mon.sv
// cv32e40p_nmr_voter_mon: TMR voter with per-replica fault streaks, retirement to duplex, sticky FAIL.
// Latency: vote and flags combinational; mode/mask/counter/log registered, visible next cycle.
// Backpressure: none; valid_i gates monitoring only. Optional first-error log: CV32E40P_NMR_ERR_LOG_EN.
module cv32e40p_nmr_voter_mon #(
  parameter int WIDTH  = 32,
  parameter int THRESH = 4,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst,
  cv32e40p_nmr_voter_mon_if.slave bus
);

  localparam int SW = $clog2(THRESH + 1);

  typedef enum logic [1:0] {
    MODE_TMR  = 2'd0,
    MODE_DEG  = 2'd1,
    MODE_FAIL = 2'd2
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [2:0]       mask_q, mask_d;
  logic [SW-1:0]    streak_q [3];
  logic [SW-1:0]    streak_d [3];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             eq12, eq13, eq23;
  logic             all_eq, three_way, healthy_diff;
  logic [1:0]       lone_id;
  logic [2:0]       retire;
  logic [WIDTH-1:0] majority, first_healthy;
  logic [WIDTH-1:0] result;
  logic             faulty, unc;
  logic [1:0]       fault_id;

  assign eq12      = (bus.res1_i == bus.res2_i);
  assign eq13      = (bus.res1_i == bus.res3_i);
  assign eq23      = (bus.res2_i == bus.res3_i);
  assign all_eq    = eq12 && eq13;
  assign three_way = !eq12 && !eq13 && !eq23;
  assign majority  = (bus.res1_i & bus.res2_i) | (bus.res1_i & bus.res3_i) |
                     (bus.res2_i & bus.res3_i);
  // At most one replica is ever retired, so replica 2 is the fallback when replica 1 is out.
  assign first_healthy = mask_q[0] ? bus.res2_i : bus.res1_i;

  // Identify the single replica that disagrees with an agreeing pair.
  always_comb begin
    lone_id = 2'd0;
    if (eq23 && !eq12)      lone_id = 2'd1;
    else if (eq13 && !eq12) lone_id = 2'd2;
    else if (eq12 && !eq13) lone_id = 2'd3;
  end

  // Disagreement among the replicas still trusted (all three when none is retired).
  always_comb begin
    case (mask_q)
      3'b001:  healthy_diff = !eq23;
      3'b010:  healthy_diff = !eq13;
      3'b100:  healthy_diff = !eq12;
      default: healthy_diff = !all_eq;
    endcase
  end

  // A lone disagreer whose streak is one short of the threshold retires on this cycle.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      retire[k] = (lone_id == 2'(k + 1)) && (streak_q[k] == SW'(THRESH - 1));
    end
  end

  // Mode state register; clear returns to TMR just like reset.
  always_ff @(posedge clk) begin
    if (rst || bus.clear_i) mode_q <= MODE_TMR;
    else                    mode_q <= mode_d;
  end

  // Mode next-state: TMR degrades on retirement or fails on three-way split; DEG fails on pair split.
  always_comb begin
    mode_d = mode_q;
    if (bus.valid_i) begin
      case (mode_q)
        MODE_TMR: begin
          if (three_way)    mode_d = MODE_FAIL;
          else if (|retire) mode_d = MODE_DEG;
        end
        MODE_DEG: begin
          if (healthy_diff) mode_d = MODE_FAIL;
        end
        default: ;
      endcase
    end
  end

  // Vote outputs per mode; FAIL keeps uncorrectable asserted regardless of inputs.
  always_comb begin
    result   = (mode_q == MODE_TMR) ? majority : first_healthy;
    faulty   = bus.valid_i && healthy_diff;
    fault_id = (bus.valid_i && mode_q == MODE_TMR) ? lone_id : 2'd0;
    unc      = (mode_q == MODE_FAIL) ||
               (bus.valid_i && ((mode_q == MODE_TMR) ? three_way : healthy_diff));
  end

  // Health bookkeeping: streaks and retirement only move in TMR, the counter in every mode.
  always_comb begin
    mask_d = mask_q;
    cnt_d  = cnt_q;
    for (int k = 0; k < 3; k++) streak_d[k] = streak_q[k];
    if (bus.valid_i && mode_q == MODE_TMR && !three_way) begin
      mask_d = mask_q | retire;
      for (int k = 0; k < 3; k++) begin
        streak_d[k] = (lone_id == 2'(k + 1)) ? streak_q[k] + 1'b1 : '0;
      end
    end
    if (faulty && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  // Health registers; clear has the same effect as reset and overrides any fault this cycle.
  always_ff @(posedge clk) begin
    if (rst || bus.clear_i) begin
      mask_q <= '0;
      cnt_q  <= '0;
      for (int k = 0; k < 3; k++) streak_q[k] <= '0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      for (int k = 0; k < 3; k++) streak_q[k] <= streak_d[k];
    end
  end

`ifdef CV32E40P_NMR_ERR_LOG_EN
  logic             log_valid_q;
  logic [1:0]       log_id_q;
  logic [WIDTH-1:0] log_data_q;
  logic [WIDTH-1:0] log_sel;

  // Offending replica value; an uncorrectable event records replica 1.
  always_comb begin
    case (fault_id)
      2'd2:    log_sel = bus.res2_i;
      2'd3:    log_sel = bus.res3_i;
      default: log_sel = bus.res1_i;
    endcase
  end

  // Capture only the first fault after reset/clear, then hold.
  always_ff @(posedge clk) begin
    if (rst || bus.clear_i) begin
      log_valid_q <= 1'b0;
      log_id_q    <= 2'd0;
      log_data_q  <= '0;
    end else if (faulty && !log_valid_q) begin
      log_valid_q <= 1'b1;
      log_id_q    <= fault_id;
      log_data_q  <= log_sel;
    end
  end

  assign bus.log_valid_o = log_valid_q;
  assign bus.log_id_o    = log_id_q;
  assign bus.log_data_o  = log_data_q;
`else
  assign bus.log_valid_o = 1'b0;
  assign bus.log_id_o    = 2'd0;
  assign bus.log_data_o  = '0;
`endif

  assign bus.result_o        = result;
  assign bus.faulty_o        = faulty;
  assign bus.fault_id_o      = fault_id;
  assign bus.uncorrectable_o = unc;
  assign bus.mode_o          = mode_q;
  assign bus.failed_mask_o   = mask_q;
  assign bus.fault_cnt_o     = cnt_q;

endmodule

// File: tb/tb_cv32e40p_nmr_voter_mon.sv
// tb_cv32e40p_nmr_voter_mon: directed scenarios plus randomized traffic against a behavioural model.
// Latency: checks combinational outputs mid-cycle, registered outputs one edge after stimulus.
// Backpressure: none; stimulus applied every cycle.
module tb_cv32e40p_nmr_voter_mon;
  localparam int W    = 32;
  localparam int TH   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef CV32E40P_NMR_ERR_LOG_EN
  localparam bit LOG_ON = 1'b1;
`else
  localparam bit LOG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  cv32e40p_nmr_voter_mon_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  cv32e40p_nmr_voter_mon #(.WIDTH(W), .THRESH(TH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state (mode 0 TMR, 1 DEG, 2 FAIL)
  int         m_mode;
  bit [2:0]   m_mask;
  int         m_streak [3];
  int         m_cnt;
  bit         m_log_vld;
  logic [1:0] m_log_id;
  logic [W-1:0] m_log_dat;
  int         m_lone;
  bit         m_three, m_disagree;
  logic [W-1:0] exp_result;
  logic       exp_faulty, exp_unc;
  logic [1:0] exp_id;

  task automatic model_reset();
    m_mode = 0; m_mask = 3'b000; m_cnt = 0;
    for (int i = 0; i < 3; i++) m_streak[i] = 0;
    m_log_vld = 1'b0; m_log_id = 2'd0; m_log_dat = '0;
  endtask

  task automatic model_eval();
    logic [W-1:0] r [3];
    logic [W-1:0] hv [$];
    int agree [3];
    int sum, first_h;
    r[0] = bus.res1_i; r[1] = bus.res2_i; r[2] = bus.res3_i;
    sum = 0;
    for (int i = 0; i < 3; i++) begin
      agree[i] = 0;
      for (int j = 0; j < 3; j++) if (i != j && r[i] == r[j]) agree[i]++;
      sum += agree[i];
    end
    m_three = (sum == 0);
    m_lone  = -1;
    if (sum == 2) for (int i = 0; i < 3; i++) if (agree[i] == 0) m_lone = i;
    first_h = -1;
    for (int i = 0; i < 3; i++) if (!m_mask[i]) begin
      if (first_h < 0) first_h = i;
      hv.push_back(r[i]);
    end
    m_disagree = 1'b0;
    foreach (hv[i]) if (hv[i] != hv[0]) m_disagree = 1'b1;
    exp_result = (m_mode == 0) ? ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2])) : r[first_h];
    exp_faulty = bus.valid_i && m_disagree;
    exp_id     = (bus.valid_i && m_mode == 0 && m_lone >= 0) ? 2'(m_lone + 1) : 2'd0;
    exp_unc    = (m_mode == 2) || (bus.valid_i && ((m_mode == 0) ? m_three : m_disagree));
  endtask

  task automatic model_step();
    if (rst || bus.clear_i) model_reset();
    else if (bus.valid_i) begin
      if (exp_faulty) begin
        if (m_cnt < CMAX) m_cnt++;
        if (!m_log_vld) begin
          m_log_vld = 1'b1; m_log_id = exp_id;
          m_log_dat = (exp_id == 2) ? bus.res2_i : (exp_id == 3) ? bus.res3_i : bus.res1_i;
        end
      end
      if (m_mode == 0) begin
        if (m_three) m_mode = 2;
        else for (int i = 0; i < 3; i++) begin
          if (i == m_lone) begin
            m_streak[i]++;
            if (m_streak[i] == TH) begin m_mask[i] = 1'b1; m_mode = 1; end
          end else m_streak[i] = 0;
        end
      end else if (m_mode == 1 && m_disagree) m_mode = 2;
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic [W-1:0] a, b, d);
    bus.valid_i = v; bus.clear_i = c; bus.res1_i = a; bus.res2_i = b; bus.res3_i = d;
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0); tick(); tick();
    nchk++; if (bus.mode_o !== 2'd0) begin nerr++; $display("FAIL reset_mode: got %0d want 0", bus.mode_o); end
    nchk++; if (bus.failed_mask_o !== 3'b000) begin nerr++; $display("FAIL reset_mask: got %b want 000", bus.failed_mask_o); end
    nchk++; if (bus.fault_cnt_o !== 2'd0) begin nerr++; $display("FAIL reset_cnt: got %0d want 0", bus.fault_cnt_o); end
    nchk++; if (bus.log_valid_o !== 1'b0 || bus.log_id_o !== 2'd0 || bus.log_data_o !== 32'h0) begin
      nerr++; $display("FAIL reset_log: got %b/%0d/%h want 0/0/0", bus.log_valid_o, bus.log_id_o, bus.log_data_o); end
    drive(1, 0, 32'h5, 32'h1, 32'h5);
    nchk++; if (bus.result_o !== 32'h5 || bus.fault_id_o !== 2'd2) begin
      nerr++; $display("FAIL reset_comb: got %h/%0d want 5/2", bus.result_o, bus.fault_id_o); end
    tick();
    nchk++; if (bus.fault_cnt_o !== 2'd0) begin nerr++; $display("FAIL reset_nocount: got %0d want 0", bus.fault_cnt_o); end
    rst = 1'b0;
  endtask

  task automatic test_all_equal();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      nchk++; if (bus.result_o !== 32'hDEADBEEF) begin nerr++; $display("FAIL eq_result: got %h want deadbeef", bus.result_o); end
      nchk++; if (bus.faulty_o !== 1'b0) begin nerr++; $display("FAIL eq_faulty: got %b want 0", bus.faulty_o); end
      tick();
      nchk++; if (bus.mode_o !== 2'd0 || bus.fault_cnt_o !== 2'd0) begin
        nerr++; $display("FAIL eq_state: got mode %0d cnt %0d want 0/0", bus.mode_o, bus.fault_cnt_o); end
    end
  endtask

  task automatic test_single_fault();
    drive(0, 0, 32'h5, 32'h1, 32'h5);
    nchk++; if (bus.faulty_o !== 1'b0 || bus.fault_id_o !== 2'd0 || bus.uncorrectable_o !== 1'b0) begin
      nerr++; $display("FAIL idle_flags: got %b/%0d/%b want 0/0/0", bus.faulty_o, bus.fault_id_o, bus.uncorrectable_o); end
    nchk++; if (bus.result_o !== 32'h5) begin nerr++; $display("FAIL idle_result: got %h want 5", bus.result_o); end
    tick();
    drive(1, 0, 32'h5, 32'h1, 32'h5);
    nchk++; if (bus.result_o !== 32'h5 || bus.fault_id_o !== 2'd2 || bus.faulty_o !== 1'b1) begin
      nerr++; $display("FAIL single_comb: got %h/%0d/%b want 5/2/1", bus.result_o, bus.fault_id_o, bus.faulty_o); end
    tick();
    drive(0, 0, 32'h5, 32'h5, 32'h5);
    nchk++; if (bus.fault_cnt_o !== 2'd1) begin nerr++; $display("FAIL single_cnt: got %0d want 1", bus.fault_cnt_o); end
    nchk++; if (bus.log_valid_o !== LOG_ON || bus.log_id_o !== (LOG_ON ? 2'd2 : 2'd0) ||
                bus.log_data_o !== (LOG_ON ? 32'h1 : 32'h0)) begin
      nerr++; $display("FAIL single_log: got %b/%0d/%h want %b", bus.log_valid_o, bus.log_id_o, bus.log_data_o, LOG_ON); end
  endtask

  task automatic test_retire();
    drive(0, 1, 0, 0, 0); tick();
    drive(1, 0, 32'h7, 32'h7, 32'h9); tick(); tick();
    drive(0, 0, 32'h7, 32'h7, 32'h9); tick();
    drive(1, 0, 32'h7, 32'h7, 32'h9); tick();
    nchk++; if (bus.mode_o !== 2'd0) begin nerr++; $display("FAIL retire_early: got mode %0d want 0", bus.mode_o); end
    nchk++; if (bus.result_o !== 32'h7 || bus.fault_id_o !== 2'd3) begin
      nerr++; $display("FAIL retire_vote: got %h/%0d want 7/3", bus.result_o, bus.fault_id_o); end
    tick();
    nchk++; if (bus.mode_o !== 2'd1 || bus.failed_mask_o !== 3'b100) begin
      nerr++; $display("FAIL retire_deg: got mode %0d mask %b want 1/100", bus.mode_o, bus.failed_mask_o); end
    drive(1, 0, 32'h5, 32'h5, 32'h9);
    nchk++; if (bus.faulty_o !== 1'b0 || bus.uncorrectable_o !== 1'b0 || bus.result_o !== 32'h5) begin
      nerr++; $display("FAIL deg_ok: got %b/%b/%h want 0/0/5", bus.faulty_o, bus.uncorrectable_o, bus.result_o); end
    tick();
    drive(1, 0, 32'hA, 32'hB, 32'hC);
    nchk++; if (bus.uncorrectable_o !== 1'b1 || bus.result_o !== 32'hA || bus.faulty_o !== 1'b1 || bus.fault_id_o !== 2'd0) begin
      nerr++; $display("FAIL deg_split: got %b/%h/%b/%0d want 1/a/1/0", bus.uncorrectable_o, bus.result_o, bus.faulty_o, bus.fault_id_o); end
    tick();
    drive(1, 0, 32'h5, 32'h5, 32'h5);
    nchk++; if (bus.mode_o !== 2'd2) begin nerr++; $display("FAIL deg_to_fail: got mode %0d want 2", bus.mode_o); end
    nchk++; if (bus.uncorrectable_o !== 1'b1 || bus.faulty_o !== 1'b0) begin
      nerr++; $display("FAIL fail_sticky: got unc %b faulty %b want 1/0", bus.uncorrectable_o, bus.faulty_o); end
    tick();
  endtask

  task automatic test_no_retire();
    drive(0, 1, 0, 0, 0); tick();
    for (int i = 0; i < 7; i++) begin
      if (i == 3) drive(1, 0, 32'h7, 32'h7, 32'h7);
      else        drive(1, 0, 32'h7, 32'h7, 32'h9);
      tick();
    end
    nchk++; if (bus.mode_o !== 2'd0 || bus.failed_mask_o !== 3'b000) begin
      nerr++; $display("FAIL no_retire: got mode %0d mask %b want 0/000", bus.mode_o, bus.failed_mask_o); end
  endtask

  task automatic test_three_way();
    drive(0, 1, 0, 0, 0); tick();
    drive(1, 0, 32'h1, 32'h2, 32'h4);
    nchk++; if (bus.uncorrectable_o !== 1'b1 || bus.result_o !== 32'h0 || bus.fault_id_o !== 2'd0 || bus.faulty_o !== 1'b1) begin
      nerr++; $display("FAIL three_comb: got %b/%h/%0d/%b want 1/0/0/1", bus.uncorrectable_o, bus.result_o, bus.fault_id_o, bus.faulty_o); end
    tick();
    nchk++; if (bus.mode_o !== 2'd2) begin nerr++; $display("FAIL three_fail: got mode %0d want 2", bus.mode_o); end
    drive(1, 1, 32'h1, 32'h2, 32'h4); tick();
    nchk++; if (bus.mode_o !== 2'd0 || bus.fault_cnt_o !== 2'd0 || bus.log_valid_o !== 1'b0) begin
      nerr++; $display("FAIL clear_wins: got mode %0d cnt %0d log %b want 0/0/0", bus.mode_o, bus.fault_cnt_o, bus.log_valid_o); end
  endtask

  task automatic test_saturate();
    logic [W-1:0] v [3];
    drive(0, 1, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      v[0] = 32'h3; v[1] = 32'h3; v[2] = 32'h3;
      v[i % 3] = 32'h8;
      drive(1, 0, v[0], v[1], v[2]); tick();
      nchk++; if (bus.fault_cnt_o !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
        nerr++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, bus.fault_cnt_o, (i + 1 > 3) ? 3 : i + 1); end
    end
    drive(1, 0, 32'h1, 32'h2, 32'h4); tick();
    rst = 1'b1; drive(0, 0, 0, 0, 0); tick(); rst = 1'b0;
    nchk++; if (bus.mode_o !== 2'd0 || bus.failed_mask_o !== 3'b0 || bus.fault_cnt_o !== 2'd0 || bus.log_valid_o !== 1'b0) begin
      nerr++; $display("FAIL rst_pulse: got %0d/%b/%0d/%b want 0/000/0/0", bus.mode_o, bus.failed_mask_o, bus.fault_cnt_o, bus.log_valid_o); end
  endtask

  task automatic test_random();
    logic [W-1:0] base, x, y, r [3];
    int sel, k, bad;
    bad = 2;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) bad = $urandom_range(0, 2);
      base = $urandom; x = $urandom | 32'h1; y = $urandom | 32'h2;
      if (x == y) y = x ^ 32'h4;
      r[0] = base; r[1] = base; r[2] = base;
      sel = $urandom_range(0, 99);
      if (sel >= 25 && sel < 85) begin
        k = ($urandom_range(0, 9) < 8) ? bad : $urandom_range(0, 2);
        r[k] = base ^ x;
      end else if (sel >= 85 && sel < 93) begin
        r[1] = base ^ x; r[2] = base ^ y;
      end else if (sel >= 93) begin
        r[0] = $urandom; r[1] = $urandom;
      end
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 3, r[0], r[1], r[2]);
      nchk++; if (bus.result_o !== exp_result) begin nerr++; $display("FAIL rnd_result@%0d: got %h want %h", n, bus.result_o, exp_result); end
      nchk++; if (bus.faulty_o !== exp_faulty) begin nerr++; $display("FAIL rnd_faulty@%0d: got %b want %b", n, bus.faulty_o, exp_faulty); end
      nchk++; if (bus.fault_id_o !== exp_id) begin nerr++; $display("FAIL rnd_id@%0d: got %0d want %0d", n, bus.fault_id_o, exp_id); end
      nchk++; if (bus.uncorrectable_o !== exp_unc) begin nerr++; $display("FAIL rnd_unc@%0d: got %b want %b", n, bus.uncorrectable_o, exp_unc); end
      nchk++; if (bus.mode_o !== 2'(m_mode) || bus.failed_mask_o !== m_mask) begin
        nerr++; $display("FAIL rnd_state@%0d: got %0d/%b want %0d/%b", n, bus.mode_o, bus.failed_mask_o, m_mode, m_mask); end
      nchk++; if (bus.fault_cnt_o !== CW'(m_cnt)) begin nerr++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", n, bus.fault_cnt_o, m_cnt); end
      nchk++; if (bus.log_valid_o !== (LOG_ON && m_log_vld) || bus.log_id_o !== (LOG_ON ? m_log_id : 2'd0) ||
                  bus.log_data_o !== (LOG_ON ? m_log_dat : '0)) begin
        nerr++; $display("FAIL rnd_log@%0d: got %b/%0d/%h", n, bus.log_valid_o, bus.log_id_o, bus.log_data_o); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_all_equal();
    test_single_fault();
    test_retire();
    test_no_retire();
    test_three_way();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
